// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types and constants for the memory copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, word geometry of the attached memory, range-check width.
package mem_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    VERIFY,
    DONE
  } state_e;

  // Word geometry of the attached memory: 32-bit words, byte addressed.
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam int MEM_BYTES      = 1024;

  // Range arithmetic width: a 10-bit base plus a 1 KiB span cannot overflow 12 bits.
  localparam int CHK_W = 12;

endpackage

// File: rtl/mem_copy_range_chk.sv
// mem_copy_range_chk: classifies a copy request before any memory access is made.
// Latency: purely combinational.
// Backpressure: none.
// Ports: src_addr, dst_addr, len (captured request) -> range_fail (either block would
//        run past the end of memory), zero_len (nothing to copy), descending (destination
//        overlaps the source from above, so the copy must run top-down to avoid clobbering).
module mem_copy_range_chk
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 9
) (
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              range_fail,
  output logic              zero_len,
  output logic              descending
);

  logic [CHK_W-1:0] span;
  logic [CHK_W-1:0] src_ext;
  logic [CHK_W-1:0] dst_ext;
  logic [CHK_W-1:0] src_end;
  logic [CHK_W-1:0] dst_end;

  always_comb begin
    span    = CHK_W'(len) * CHK_W'(BYTES_PER_WORD);
    src_ext = CHK_W'(src_addr);
    dst_ext = CHK_W'(dst_addr);
    src_end = src_ext + span;
    dst_end = dst_ext + span;

    // An end address equal to MEM_BYTES is legal: the last byte touched is MEM_BYTES-1.
    range_fail = (src_end > CHK_W'(MEM_BYTES)) || (dst_end > CHK_W'(MEM_BYTES));
    zero_len   = (len == '0);
    descending = (dst_ext > src_ext) && (dst_ext < src_end);
  end

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-granular memmove within a 1 KiB byte-addressed memory.
// Latency: CHECK one cycle after start, then 2 cycles per word (3 with verify); done at 2 + 2*len.
// Backpressure: none; start is only sampled in IDLE and the memory is zero-wait.
// Optional feature: define MEM_COPY_VERIFY_EN to add a read-back VERIFY state after every WRITE.
// Ports: clk, rst (synchronous, active-high); start, src_addr, dst_addr, len (request);
//        busy, done, err (status); mem_write, mem_read, mem_addr, mem_wrdata, mem_rddata (memory).
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = WORD_W,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic [DATA_W-1:0] mem_rddata
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              range_fail;
  logic              zero_len;
  logic              descending;
  logic [ADDR_W-1:0] last_off;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic              advance;
  logic              finish;

  // Classifies the captured request; only its CHECK-cycle result is acted upon.
  mem_copy_range_chk #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_range_chk (
    .src_addr  (src_base_q),
    .dst_addr  (dst_base_q),
    .len       (len_q),
    .range_fail(range_fail),
    .zero_len  (zero_len),
    .descending(descending)
  );

  always_comb begin
    state_d     = state_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    len_d       = len_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    rem_d       = rem_q;
    desc_d      = desc_q;
    data_d      = data_q;
    busy_d      = busy_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    done_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;

    // Offset of the last word; only meaningful once len is known to be non-zero.
    last_off = ADDR_W'(len_q - LEN_W'(1)) * STEP;
    src_next = desc_q ? (src_ptr_q - STEP) : (src_ptr_q + STEP);
    dst_next = desc_q ? (dst_ptr_q - STEP) : (dst_ptr_q + STEP);

    // Strobes and address are registered, so each branch sets up the bus for the
    // state being entered rather than the state being left.
    case (state_q)
      IDLE: begin
        if (start) begin
          src_base_d = src_addr;
          dst_base_d = dst_addr;
          len_d      = len;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = CHECK;
        end
      end

      CHECK: begin
        if (range_fail) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else if (zero_len) begin
          finish = 1'b1;
        end else begin
          desc_d     = descending;
          src_ptr_d  = descending ? (src_base_q + last_off) : src_base_q;
          dst_ptr_d  = descending ? (dst_base_q + last_off) : dst_base_q;
          rem_d      = len_q;
          mem_read_d = 1'b1;
          mem_addr_d = src_ptr_d;
          state_d    = READ;
        end
      end

      READ: begin
        data_d      = mem_rddata;
        mem_write_d = 1'b1;
        mem_addr_d  = dst_ptr_q;
        state_d     = WRITE;
      end

      WRITE: begin
`ifdef MEM_COPY_VERIFY_EN
        // Read back the word just written; pointers step only once it is confirmed.
        mem_read_d = 1'b1;
        mem_addr_d = dst_ptr_q;
        state_d    = VERIFY;
`else
        advance = 1'b1;
`endif
      end

`ifdef MEM_COPY_VERIFY_EN
      VERIFY: begin
        if (mem_rddata != data_q) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      src_ptr_d = src_next;
      dst_ptr_d = dst_next;
      rem_d     = rem_q - LEN_W'(1);
      if (rem_q != LEN_W'(1)) begin
        mem_read_d = 1'b1;
        mem_addr_d = src_next;
        state_d    = READ;
      end else begin
        finish = 1'b1;
      end
    end

    if (finish) begin
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      rem_q       <= '0;
      desc_q      <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      len_q       <= len_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      rem_q       <= rem_d;
      desc_q      <= desc_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wrdata = data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: self-checking bench for mem_copy_engine with a behavioural 1 KiB memory.
// Expected write beats and done pulses are queued when a request is issued and popped as the
// bus produces them; the memory image is compared against a memmove reference after each copy.
module tb_mem_copy_engine;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;
`ifdef MEM_COPY_VERIFY_EN
  localparam int CPW = 3;
`else
  localparam int CPW = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, err, mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrdata;
  logic [DATA_W-1:0] mem_rddata;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wrdata(mem_wrdata),
    .mem_rddata(mem_rddata)
  );

  // Behavioural memory: combinational read, write on the edge. It shares the system reset,
  // so a strobe still on the bus at the reset edge is not committed. The backdoor port
  // preloads contents while the engine is idle.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_dat = '0;

  assign mem_rddata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_dat;
    else if (mem_write && !rst) mem[mem_addr[9:2]] <= mem_wrdata;
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int   cyc;
    logic err;
  } done_exp_t;

  typedef struct {
    logic [9:0] src;
    logic [9:0] dst;
    int         len;
    int         preload;  // 0 none, 1 = 0x11111111 ramp, 2 = 0xA0 ramp, at words 0..3
    logic       exp_err;
    int         junk;     // cycles of ignored start pulses while busy
  } vec_t;

  wr_exp_t   wr_exp_q[$];
  done_exp_t done_exp_q[$];
  vec_t      vecs[11];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int both_hi = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One clock: advance to just after the rising edge and check what the bus shows.
  task automatic tick();
    wr_exp_t   e;
    done_exp_t d;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_read && mem_write) both_hi++;
    if (mem_write) begin
      tests++;
      if (wr_exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", mem_addr, mem_wrdata);
      end else begin
        e = wr_exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wrdata !== e.data) begin
          fails++;
          $display("FAIL write_beat: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   mem_addr, mem_wrdata, e.addr, e.data);
        end
      end
    end
    if (done) begin
      tests++;
      if (done_exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        d = done_exp_q.pop_front();
        if (cyc != d.cyc || err !== d.err) begin
          fails++;
          $display("FAIL done_pulse: got cycle=%0d err=%0b, expected cycle=%0d err=%0b",
                   cyc, err, d.cyc, d.err);
        end
      end
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] dat);
    bd_we  = 1'b1;
    bd_idx = 8'(idx);
    bd_dat = dat;
    tick();
    bd_we  = 1'b0;
    ref_mem[idx] = dat;
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [31:0] srcw [256];
    wr_exp_t     w;
    done_exp_t   d;
    int          s, dd, n, idx;
    logic        desc;

    if (v.preload == 1) for (int i = 0; i < 4; i++) bd_write(i, 32'h11111111 * 32'(i + 1));
    if (v.preload == 2) for (int i = 0; i < 4; i++) bd_write(i, 32'hA0 + 32'(i));

    s    = int'(v.src);
    dd   = int'(v.dst);
    desc = (dd > s) && (dd < s + 4 * v.len);
    if (!v.exp_err) for (int i = 0; i < v.len; i++) srcw[i] = ref_mem[s / 4 + i];

    if (!v.exp_err) begin
      for (int j = 0; j < v.len; j++) begin
        idx    = desc ? (v.len - 1 - j) : j;
        w.addr = 10'(dd + 4 * idx);
        w.data = srcw[idx];
        wr_exp_q.push_back(w);
      end
    end
    d.cyc = cyc + ((v.exp_err || v.len == 0) ? 2 : 2 + CPW * v.len);
    d.err = v.exp_err;
    done_exp_q.push_back(d);

    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = 9'(v.len);
    tick();
    start = 1'b0;
    check($sformatf("v%0d_check_state", k), {29'd0, busy, mem_read, mem_write}, 32'b100);

    if (v.junk > 0) begin
      start    = 1'b1;
      src_addr = 10'h300;
      dst_addr = 10'h000;
      len      = 9'd2;
      repeat (v.junk) tick();
      start = 1'b0;
    end

    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("v%0d_done_seen", k), {31'd0, done}, 32'd1);

    tick();
    check($sformatf("v%0d_idle_status", k), {29'd0, busy, done, err}, {29'd0, 2'b00, v.exp_err});

    if (!v.exp_err) for (int i = 0; i < v.len; i++) ref_mem[dd / 4 + i] = srcw[i];
    check_mem($sformatf("v%0d_mem_image", k));
  endtask

  initial begin
    wr_exp_t w;

    vecs[0]  = '{src: 10'h000, dst: 10'h100, len: 4,   preload: 1, exp_err: 1'b0, junk: 0};
    vecs[1]  = '{src: 10'h000, dst: 10'h004, len: 4,   preload: 2, exp_err: 1'b0, junk: 0};
    vecs[2]  = '{src: 10'h3F8, dst: 10'h000, len: 3,   preload: 0, exp_err: 1'b1, junk: 0};
    vecs[3]  = '{src: 10'h010, dst: 10'h020, len: 0,   preload: 0, exp_err: 1'b0, junk: 0};
    vecs[4]  = '{src: 10'h000, dst: 10'h3FC, len: 1,   preload: 0, exp_err: 1'b0, junk: 0};
    vecs[5]  = '{src: 10'h000, dst: 10'h3F0, len: 5,   preload: 0, exp_err: 1'b1, junk: 0};
    vecs[6]  = '{src: 10'h000, dst: 10'h200, len: 128, preload: 0, exp_err: 1'b0, junk: 0};
    vecs[7]  = '{src: 10'h040, dst: 10'h038, len: 4,   preload: 0, exp_err: 1'b0, junk: 0};
    vecs[8]  = '{src: 10'h080, dst: 10'h180, len: 4,   preload: 0, exp_err: 1'b0, junk: 5};
    vecs[9]  = '{src: 10'h3F0, dst: 10'h100, len: 4,   preload: 0, exp_err: 1'b0, junk: 0};
    vecs[10] = '{src: 10'h000, dst: 10'h000, len: 256, preload: 0, exp_err: 1'b0, junk: 0};

    rst = 1'b1;
    tick();
    tick();
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_err",    {31'd0, err},       32'd0);
    check("rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr",   32'(mem_addr),      32'd0);
    check("rst_wrdata", mem_wrdata,         32'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) bd_write(i, $urandom());

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

    // Reset while the third word of an 8-word copy is on the bus.
    for (int i = 0; i < 8; i++) bd_write(192 + i, ~ref_mem[i]);
    for (int i = 0; i < 3; i++) begin
      w.addr = 10'(768 + 4 * i);
      w.data = ref_mem[i];
      wr_exp_q.push_back(w);
    end
    start    = 1'b1;
    src_addr = 10'h000;
    dst_addr = 10'h300;
    len      = 9'd8;
    tick();
    start = 1'b0;
    repeat (2 + 2 * CPW) tick();
    check("rst_mid_third_write", {21'd0, mem_write, mem_addr}, {21'd0, 1'b1, 10'h308});
    rst = 1'b1;
    tick();
    check("rst_mid_status",  {29'd0, busy, done, err}, 32'd0);
    check("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;
    ref_mem[192] = ref_mem[0];
    ref_mem[193] = ref_mem[1];
    repeat (3) tick();
    check("rst_mid_stays_idle", {31'd0, busy}, 32'd0);
    check_mem("rst_mid_mem_image");

    check("no_read_write_overlap", 32'(both_hi), 32'd0);
    check("writes_drained", 32'(wr_exp_q.size()), 32'd0);
    check("dones_drained", 32'(done_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
